mask_frame_writer: RTL
======================

MASK_FRAME_WRITER -- requirements
Module: mask_frame_writer

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 Parameter ADDR_WIDTH, default 19, write-address width; must satisfy 2**ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT.
REQ-004 Parameter DATA_WIDTH, default 1, mask pixel width.
REQ-005 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 Port in_valid, input, 1, upstream pixel valid.
REQ-008 Port in_ready, output, 1, block accepts pixel; transfer occurs when in_valid && in_ready.
REQ-009 Port in_data, input, DATA_WIDTH, mask pixel, raster order.
REQ-010 Port in_sop, input, 1, marks first pixel of frame.
REQ-011 Port in_eop, input, 1, marks last pixel of frame.
REQ-012 Port hold, input, 1, downstream reading buffer; blocks start of new frame.
REQ-013 Port we, output, 1, buffer write enable.
REQ-014 Port waddr, output, ADDR_WIDTH, buffer write address.
REQ-015 Port wdata, output, DATA_WIDTH, buffer write data.
REQ-016 Port busy, output, 1, frame capture in progress.
REQ-017 Port frame_done, output, 1, one-cycle pulse: complete frame written.
REQ-018 Port frame_error, output, 1, one-cycle pulse: malformed frame detected.

Function
REQ-019 States: IDLE, WRITE, DRAIN.
REQ-020 IDLE: in_ready = !hold; accepted pixels without in_sop are discarded; accepted pixel with in_sop is written to address 0 and moves to WRITE.
REQ-021 WRITE: in_ready = 1; each accepted pixel is written to the next address (addr+1, row-major, no gaps); busy = 1.
REQ-022 Write latency: we/waddr/wdata are registered, asserted exactly one cycle after the accepting edge; we = 0 on cycles with no accepted written pixel.
REQ-023 Pixel at address IMG_WIDTH*IMG_HEIGHT-1 with in_eop: frame_done pulses in the same cycle as its we; return to IDLE.
REQ-024 in_eop on a pixel before the last address: pixel written, frame_error pulses with its we, frame_done stays 0, return to IDLE.
REQ-025 Last address reached without in_eop: pixel written, frame_error pulses, move to DRAIN.
REQ-026 DRAIN: in_ready = 1, pixels discarded (no we), busy = 1; accepted in_eop returns to IDLE; accepted in_sop restarts capture at address 0 in WRITE.
REQ-027 in_sop accepted in WRITE (mid-frame): frame_error pulses, pixel written to address 0, counter restarts, state stays WRITE.
REQ-028 in_sop && in_eop on one pixel: treated as in_sop then in_eop; with IMG_WIDTH*IMG_HEIGHT > 1 gives frame_error and return to IDLE.
REQ-029 hold is sampled only in IDLE; hold asserted during WRITE/DRAIN does not stall or abort the frame.
REQ-030 Address counter never exceeds IMG_WIDTH*IMG_HEIGHT-1; no wrap-around write.
REQ-031 frame_done and frame_error never assert in the same cycle.

Reset
REQ-032 rst_n low forces state IDLE, counter 0, we 0, waddr 0, wdata 0, busy 0, frame_done 0, frame_error 0, asynchronously.
REQ-033 Reset mid-frame abandons the frame without any pulse; capture resumes only on the next in_sop after release.
REQ-034 in_ready is 0 while rst_n is low.

Structure
REQ-035 State enum and derived constant FRAME_PIXELS (IMG_WIDTH*IMG_HEIGHT) reside in shared package pattern_rec_pkg.
REQ-036 Single flat module, no sub-modules; outputs drive the buffer's write port directly.

Verification
REQ-037 4x2 frame, sop first, eop on 8th pixel, in_valid continuous -> we on 8 cycles, waddr 0..7, frame_done one pulse with waddr=7.
REQ-038 4x2 frame, eop on 5th pixel -> writes 0..4, frame_error pulse with waddr=4, no frame_done, next sop writes address 0.
REQ-039 4x2, 10 pixels without eop, eop on 10th -> writes 0..7, frame_error at waddr=7, pixels 9-10 not written, state IDLE afterward.
REQ-040 hold=1 in IDLE with sop pending -> in_ready=0, no we; hold falls -> sop accepted, waddr=0 one cycle later.
REQ-041 sop re-asserted on 4th pixel of a frame -> frame_error pulse, that pixel written at address 0, following pixels 1,2,...
REQ-042 rst_n low after 3 pixels -> all outputs 0 immediately; non-sop pixels after release discarded until next sop.

Source files
------------

// File: rtl/pattern_rec_pkg.sv
// Shared definitions for the pattern-recognition mask path.
// Holds the frame writer state encoding, the default image geometry,
// the derived default frame size, and a helper that derives the frame
// size from any width/height pair so modules with overridden geometry
// compute it the same way.
// Ports: none (package only).
package pattern_rec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2
    } writer_state_e;

    localparam int IMG_WIDTH_DEFAULT  = 640;
    localparam int IMG_HEIGHT_DEFAULT = 480;
    localparam int FRAME_PIXELS       = IMG_WIDTH_DEFAULT * IMG_HEIGHT_DEFAULT;

    function automatic int calc_frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/mask_frame_writer.sv
// Mask frame writer: takes a raster-order stream of mask pixels framed by
// sop/eop markers and writes one complete frame into a buffer, one pixel
// per address starting at 0. Malformed frames (early eop, missing eop,
// sop restarting mid-frame) are flagged with a frame_error pulse.
// Ports:
//   clk, rst_n          - clock (rising edge) and async active-low reset
//   in_valid/in_ready   - upstream handshake, transfer when both high
//   in_data             - mask pixel
//   in_sop/in_eop       - first/last pixel of frame markers
//   hold                - downstream is reading; blocks start of a new frame
//   we/waddr/wdata      - registered buffer write port
//   busy                - capture in progress (WRITE or DRAIN)
//   frame_done          - one-cycle pulse with the final write of a good frame
//   frame_error         - one-cycle pulse with the write/pixel that broke a frame
module mask_frame_writer
    import pattern_rec_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  hold,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_error
);

    localparam int FRAME_PIXELS_P = calc_frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS_P - 1);

    writer_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    wr_en;
    logic                    capture;
    logic                    done_d;
    logic                    err_d;
    logic                    accept;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    done_q;
    logic                    err_q;

    // hold only gates the start of a frame; once capturing, every pixel is
    // taken so the upstream stream is never stalled mid-frame. Ready is
    // forced low during reset so nothing is handshaken while the block is
    // not listening.
    assign in_ready = rst_n && ((state_q == ST_IDLE) ? !hold : 1'b1);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);

    // State and address counter registers. count_q holds the address the
    // next non-sop pixel will be written to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. Every pixel that is to be written goes through the
    // common "capture" path: sop always restarts at address 0, and the
    // eop/last-address combination decides between done, error-and-idle,
    // or error-and-drain. This makes sop+eop on one pixel behave as sop
    // followed by eop, and lets DRAIN restart a frame the same way IDLE does.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        wr_en   = 1'b0;
        wr_addr = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && in_sop) begin
                    capture = 1'b1;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    capture = 1'b1;
                    if (in_sop) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    if (in_sop) begin
                        capture = 1'b1;
                    end else if (in_eop) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        if (capture) begin
            wr_en   = 1'b1;
            wr_addr = in_sop ? '0 : count_q;
            if (wr_addr == LAST_ADDR) begin
                // Counter stops here: either the frame closed cleanly or the
                // remaining pixels are thrown away in DRAIN.
                count_d = '0;
                if (in_eop) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end else if (in_eop) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                count_d = '0;
            end else begin
                state_d = ST_WRITE;
                count_d = wr_addr + 1'b1;
            end
        end

        // A frame that was already broken by a restarting sop cannot also
        // count as complete.
        if (err_d) begin
            done_d = 1'b0;
        end
    end

    // Registered write port and status pulses, all aligned to the cycle
    // after the accepting edge. waddr/wdata keep their last value when no
    // write happens; only we qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= wr_en;
            done_q <= done_d;
            err_q  <= err_d;
            if (wr_en) begin
                waddr_q <= wr_addr;
                wdata_q <= in_data;
            end
        end
    end

    assign we          = we_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign frame_done  = done_q;
    assign frame_error = err_q;

endmodule
